// File: rtl/drfm_pkg.sv
// drfm_pkg: shared definitions for the DRFM mode controller.
//   - display mode codes (ST_WAIT, ST_LOAD, ST_ERR)
//   - bit positions of the effect enables inside the RUN mode code
//   - FSM state enumeration
//   - run_code(): builds the RUN-state display code from the three enables
package drfm_pkg;

  localparam logic [3:0] ST_WAIT = 4'b0000;
  localparam logic [3:0] ST_LOAD = 4'b0100;
  localparam logic [3:0] ST_ERR  = 4'b1111;

  localparam int DELAY_BIT   = 0;
  localparam int SCALE_BIT   = 1;
  localparam int DOPPLER_BIT = 3;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    ERR  = 2'd2
  } fsm_t;

  // RUN display code: enables dropped into their bit positions, bit 2 stays 0
  // so a RUN code can never alias ST_LOAD or ST_ERR.
  function automatic logic [3:0] run_code(input logic delay, input logic scale,
                                          input logic doppler);
    logic [3:0] code;
    code              = ST_WAIT;
    code[DELAY_BIT]   = delay;
    code[SCALE_BIT]   = scale;
    code[DOPPLER_BIT] = doppler;
    return code;
  endfunction

endpackage

// File: rtl/drfm_mode_controller_debounce.sv
// button_debounce: one front-panel push-button conditioner.
//   clk     in  system clock
//   reset   in  asynchronous active-high reset (button reads released)
//   btn_n   in  raw active-low button pin, asynchronous to clk
//   press   out one-cycle pulse on the accepted released->pressed transition
// The pin passes a 2-FF synchroniser; the accepted level only follows the
// synchronised level after DEBOUNCE_CYCLES consecutive cycles of disagreement.
// Releases are debounced the same way but produce no pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          pressed_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;
  logic          raw_pressed;

  assign raw_pressed = ~sync2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      pressed_reg <= 1'b0;
      press_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (raw_pressed == pressed_reg) begin
        // any bounce back to the accepted level restarts the qualification
        cnt_reg <= '0;
      end else if (cnt_reg >= CNT_LAST) begin
        // this is the DEBOUNCE_CYCLES-th consecutive differing cycle
        pressed_reg <= raw_pressed;
        press_reg   <= raw_pressed;
        cnt_reg     <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/drfm_mode_controller.sv
// drfm_mode_controller: DRFM operating-mode sequencer.
//   clk            in  system clock
//   reset          in  asynchronous active-high reset
//   btn_*_n        in  delay/scale/doppler/load push-buttons, active-low, async
//   load_done      in  one-cycle pulse: sample buffer filled
//   state          out 4-bit display mode code (registered)
//   delay_en/scale_en/doppler_en  out effect enables
//   load_start     out one-cycle pulse: datapath begins buffer fill
//   cfg_strobe     out one-cycle pulse the cycle after any enable changes
// Build option: define DRFM_LOAD_TIMEOUT_EN to add the LOAD timeout counter and
// the ERR state. Without it, LOAD waits for load_done indefinitely.
module drfm_mode_controller
  import drfm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOAD_TIMEOUT    = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_delay_n,
  input  logic       btn_scale_n,
  input  logic       btn_doppler_n,
  input  logic       btn_load_n,
  input  logic       load_done,
  output logic [3:0] state,
  output logic       delay_en,
  output logic       scale_en,
  output logic       doppler_en,
  output logic       load_start,
  output logic       cfg_strobe
);

  // press_vec / en_* bit order: 0 delay, 1 scale, 2 doppler, 3 load
  localparam int P_LOAD = 3;

  logic [3:0] btn_n_vec;
  logic [3:0] press_vec;

  assign btn_n_vec = {btn_load_n, btn_doppler_n, btn_scale_n, btn_delay_n};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_n_vec[gi]),
        .press(press_vec[gi])
      );
    end
  endgenerate

  fsm_t       fsm_reg, fsm_next;
  logic [2:0] en_reg, en_next;
  logic [2:0] en_d_reg;
  logic [3:0] mode_reg, mode_next;
  logic       load_start_reg, load_start_next;
  logic       cfg_strobe_reg;
  logic       tmo_hit;

`ifdef DRFM_LOAD_TIMEOUT_EN
  localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(LOAD_TIMEOUT - 1);

  logic [TW-1:0] tmo_reg, tmo_next;

  assign tmo_hit = (tmo_reg == TMO_LAST);

  // Counts only while staying in LOAD; any entry into LOAD starts from zero.
  always_comb begin
    tmo_next = '0;
    if (fsm_reg == LOAD && fsm_next == LOAD) begin
      tmo_next = tmo_hit ? tmo_reg : tmo_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_next;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    fsm_next        = fsm_reg;
    en_next         = en_reg;
    load_start_next = 1'b0;
    mode_next       = ST_WAIT;

    case (fsm_reg)
      RUN: begin
        // load has priority; same-cycle toggle presses are dropped
        if (press_vec[P_LOAD]) begin
          fsm_next        = LOAD;
          load_start_next = 1'b1;
        end else begin
          en_next = en_reg ^ press_vec[2:0];
        end
      end
      LOAD: begin
        // load_done beats a timeout expiring in the same cycle
        if (load_done) begin
          fsm_next = RUN;
        end else if (tmo_hit) begin
          fsm_next = ERR;
          en_next  = '0;
        end
      end
      ERR: begin
        en_next = '0;
        if (press_vec[P_LOAD]) begin
          fsm_next        = LOAD;
          load_start_next = 1'b1;
        end
      end
      default: begin
        fsm_next = RUN;
        en_next  = '0;
      end
    endcase

    // display code tracks the next state so it changes with the FSM
    case (fsm_next)
      RUN:     mode_next = run_code(en_next[0], en_next[1], en_next[2]);
      LOAD:    mode_next = ST_LOAD;
      ERR:     mode_next = ST_ERR;
      default: mode_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg        <= RUN;
      en_reg         <= '0;
      en_d_reg       <= '0;
      mode_reg       <= ST_WAIT;
      load_start_reg <= 1'b0;
      cfg_strobe_reg <= 1'b0;
    end else begin
      fsm_reg        <= fsm_next;
      en_reg         <= en_next;
      en_d_reg       <= en_reg;
      mode_reg       <= mode_next;
      load_start_reg <= load_start_next;
      // compares against the delayed copy, so the strobe trails the change
      cfg_strobe_reg <= (en_reg != en_d_reg);
    end
  end

  assign state      = mode_reg;
  assign delay_en   = en_reg[0];
  assign scale_en   = en_reg[1];
  assign doppler_en = en_reg[2];
  assign load_start = load_start_reg;
  assign cfg_strobe = cfg_strobe_reg;

endmodule

// File: tb/tb_drfm_mode_controller.sv
// Directed bench for drfm_mode_controller with DEBOUNCE_CYCLES=4, LOAD_TIMEOUT=16.
// Timeout/ERR vectors run when DRFM_LOAD_TIMEOUT_EN is defined; otherwise the
// indefinite LOAD hold is exercised instead.
module tb_drfm_mode_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_n;       // 0 delay, 1 scale, 2 doppler, 3 load
  logic       load_done;
  logic [3:0] state;
  logic       delay_en, scale_en, doppler_en, load_start, cfg_strobe;

  int n_vec = 0;
  int n_err = 0;
  int ls_cnt = 0;
  int cs_cnt = 0;
  int ls_base, cs_base;

  always #5 clk = ~clk;

  drfm_mode_controller #(
    .DEBOUNCE_CYCLES(4),
    .LOAD_TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_delay_n  (btn_n[0]),
    .btn_scale_n  (btn_n[1]),
    .btn_doppler_n(btn_n[2]),
    .btn_load_n   (btn_n[3]),
    .load_done    (load_done),
    .state        (state),
    .delay_en     (delay_en),
    .scale_en     (scale_en),
    .doppler_en   (doppler_en),
    .load_start   (load_start),
    .cfg_strobe   (cfg_strobe)
  );

  // pulse tallies, sampled mid-cycle
  always @(negedge clk) begin
    if (load_start) ls_cnt++;
    if (cfg_strobe) cs_cnt++;
  end

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn_n[idx] = 1'b0;
    tick(10);
    btn_n[idx] = 1'b1;
    tick(10);
  endtask

  initial begin
    reset     = 1'b1;
    btn_n     = 4'hF;
    load_done = 1'b0;
    tick(3);
    reset = 1'b0;

    // idle after reset
    tick(20);
    check_vec("rst_state", state, 4'b0000);
    check_vec("rst_en", {delay_en, scale_en, doppler_en}, 3'b000);
    check_vec("rst_ls", ls_cnt, 0);
    check_vec("rst_cs", cs_cnt, 0);

    // delay press with exact latency
    cs_base = cs_cnt;
    btn_n[0] = 1'b0;
    tick(6);
    check_vec("dly_early", delay_en, 1'b0);
    tick(1);
    check_vec("dly_en", delay_en, 1'b1);
    check_vec("dly_state", state, 4'b0001);
    check_vec("dly_cs_lag", cfg_strobe, 1'b0);
    tick(1);
    check_vec("dly_cs", cfg_strobe, 1'b1);
    tick(1);
    check_vec("dly_cs_end", cfg_strobe, 1'b0);
    tick(1);
    btn_n[0] = 1'b1;
    tick(10);
    check_vec("dly_release", state, 4'b0001);
    check_vec("dly_cs_cnt", cs_cnt - cs_base, 1);

    // 2-cycle glitch is rejected
    btn_n[0] = 1'b0;
    tick(2);
    btn_n[0] = 1'b1;
    tick(12);
    check_vec("glitch_state", state, 4'b0001);
    check_vec("glitch_cs", cs_cnt - cs_base, 1);

    // toggle delay back off
    press(0);
    check_vec("dly_off", state, 4'b0000);

    // scale + doppler on the same edge
    cs_base = cs_cnt;
    btn_n[1] = 1'b0;
    btn_n[2] = 1'b0;
    tick(6);
    check_vec("dual_early", state, 4'b0000);
    tick(1);
    check_vec("dual_state", state, 4'b1010);
    check_vec("dual_en", {delay_en, scale_en, doppler_en}, 3'b011);
    tick(3);
    btn_n[1] = 1'b1;
    btn_n[2] = 1'b1;
    tick(10);
    check_vec("dual_cs", cs_cnt - cs_base, 1);

    press(0);
    check_vec("all_on", state, 4'b1011);

    // load_done outside LOAD
    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
    tick(1);
    check_vec("ld_outside", state, 4'b1011);

    // load with doppler press ignored, then load_done
    ls_base = ls_cnt;
    btn_n[3] = 1'b0;
    tick(6);
    check_vec("ld_early", load_start, 1'b0);
    tick(1);
    check_vec("ld_start", load_start, 1'b1);
    check_vec("ld_state", state, 4'b0100);
    tick(1);
    check_vec("ld_start_end", load_start, 1'b0);
    btn_n[3] = 1'b1;
    btn_n[2] = 1'b0;
    tick(8);
    check_vec("ld_dop_ign", doppler_en, 1'b1);
    check_vec("ld_hold", state, 4'b0100);
    btn_n[2] = 1'b1;
    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
    check_vec("ld_done", state, 4'b1011);
    tick(10);
    check_vec("ld_ls_cnt", ls_cnt - ls_base, 1);
    check_vec("ld_after", state, 4'b1011);

`ifdef DRFM_LOAD_TIMEOUT_EN
    // timeout into ERR
    cs_base = cs_cnt;
    btn_n[3] = 1'b0;
    tick(7);
    check_vec("tmo_entry", state, 4'b0100);
    btn_n[3] = 1'b1;
    tick(15);
    check_vec("tmo_pre", state, 4'b0100);
    tick(1);
    check_vec("tmo_err", state, 4'b1111);
    check_vec("tmo_en", {delay_en, scale_en, doppler_en}, 3'b000);
    tick(1);
    check_vec("tmo_cs", cfg_strobe, 1'b1);
    tick(1);
    check_vec("tmo_cs_end", cfg_strobe, 1'b0);
    check_vec("tmo_cs_cnt", cs_cnt - cs_base, 1);

    press(0);
    check_vec("err_tog_ign", state, 4'b1111);

    // reload from ERR, load_done exactly in the expiry cycle
    ls_base = ls_cnt;
    btn_n[3] = 1'b0;
    tick(7);
    check_vec("err_reload", state, 4'b0100);
    check_vec("err_ls", load_start, 1'b1);
    btn_n[3] = 1'b1;
    tick(15);
    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
    check_vec("expiry_done", state, 4'b0000);
    tick(5);
    check_vec("expiry_after", state, 4'b0000);
    check_vec("expiry_ls", ls_cnt - ls_base, 1);
`else
    // no timeout: LOAD holds indefinitely
    btn_n[3] = 1'b0;
    tick(7);
    check_vec("nt_entry", state, 4'b0100);
    btn_n[3] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check_vec("nt_hold", state, 4'b0100);
    end
    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
    check_vec("nt_done", state, 4'b1011);
`endif

    // reset mid-LOAD
    btn_n[3] = 1'b0;
    tick(7);
    check_vec("rl_entry", state, 4'b0100);
    btn_n[3] = 1'b1;
    tick(3);
    ls_base = ls_cnt;
    reset = 1'b1;
    #1;
    check_vec("rl_async", state, 4'b0000);
    check_vec("rl_en", {delay_en, scale_en, doppler_en}, 3'b000);
    tick(3);
    reset = 1'b0;
    tick(20);
    check_vec("rl_after", state, 4'b0000);
    check_vec("rl_ls", ls_cnt - ls_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
